// File: rtl/mult_result_accum.sv
// Sums four signed channel products per valid frame and accumulates ACC_LEN frames per window.
// Optional build macro ACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module mult_result_accum #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ACC_W   = 20,
   parameter int unsigned ACC_LEN = 16
) (
   input  logic                     Clock_20M,
   input  logic                     Ex_Rst_n,
   input  logic                     Start,
   input  logic                     Stop,
   input  logic                     In_Valid,
   input  logic signed [DATA_W-1:0] Result0,
   input  logic signed [DATA_W-1:0] Result1,
   input  logic signed [DATA_W-1:0] Result2,
   input  logic signed [DATA_W-1:0] Result3,
   output logic signed [ACC_W-1:0]  Acc_Out,
   output logic                     Acc_Valid,
   output logic                     Busy,
   output logic                     Overflow
);

   localparam int unsigned S1_W  = DATA_W + 1;
   localparam int unsigned S2_W  = DATA_W + 2;
   localparam int unsigned NXT_W = ACC_W + 1;
   localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t state, state_nxt;

   logic signed [S1_W-1:0]  s01, s23;
   logic signed [S2_W-1:0]  fsum;
   logic                    v1, v2;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        count;
   logic signed [ACC_W-1:0] dump_val;
   logic                    dump_v;

   logic                    flush_c;
   logic                    frame_ok_c;
   logic signed [NXT_W-1:0] nxt_c;
   logic                    ovf_c;
   logic signed [ACC_W-1:0] res_c;

   // State register
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   // Next state: Stop dominates a coincident Start
   always_comb begin
      state_nxt  = state;
      flush_c    = Start | Stop;
      frame_ok_c = In_Valid & (state == ACCUM) & ~Start & ~Stop;
      case (state)
         IDLE:    if (Start && !Stop) state_nxt = ACCUM;
         ACCUM:   if (Stop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Adder tree, stage 1: channel pairs
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         s01 <= '0;
         s23 <= '0;
         v1  <= 1'b0;
      end else begin
         s01 <= S1_W'(Result0) + S1_W'(Result1);
         s23 <= S1_W'(Result2) + S1_W'(Result3);
         v1  <= frame_ok_c;
      end
   end

   // Adder tree, stage 2: frame sum
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         fsum <= '0;
         v2   <= 1'b0;
      end else begin
         fsum <= S2_W'(s01) + S2_W'(s23);
         v2   <= v1 & ~flush_c;
      end
   end

   // One guard bit above the accumulator exposes signed overflow
   always_comb begin
      nxt_c = NXT_W'(acc) + NXT_W'(fsum);
      ovf_c = nxt_c[ACC_W] ^ nxt_c[ACC_W-1];
`ifdef ACC_SAT_EN
      if (ovf_c) res_c = nxt_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else       res_c = nxt_c[ACC_W-1:0];
`else
      res_c = nxt_c[ACC_W-1:0];
`endif
   end

   // Window accumulator and frame counter
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         acc      <= '0;
         count    <= '0;
         dump_val <= '0;
         dump_v   <= 1'b0;
         Overflow <= 1'b0;
      end else if (flush_c) begin
         acc    <= '0;
         count  <= '0;
         dump_v <= 1'b0;
         if (!Stop) Overflow <= 1'b0;
      end else begin
         dump_v <= 1'b0;
         if (v2) begin
            if (ovf_c) Overflow <= 1'b1;
            if (count == CNT_LAST) begin
               dump_val <= res_c;
               dump_v   <= 1'b1;
               acc      <= '0;
               count    <= '0;
            end else begin
               acc   <= res_c;
               count <= count + CNT_W'(1);
            end
         end
      end
   end

   // Registered outputs; Acc_Out holds until the next completed window
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         Acc_Out   <= '0;
         Acc_Valid <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         Acc_Valid <= dump_v;
         Busy      <= (state_nxt == ACCUM);
         if (dump_v) Acc_Out <= dump_val;
      end
   end

endmodule

// File: tb/tb_mult_result_accum.sv
// Directed self-checking bench for mult_result_accum (default parameters).
// Expected T4 result follows the ACC_SAT_EN build macro.
module tb_mult_result_accum;

   logic               Clock_20M;
   logic               Ex_Rst_n;
   logic               Start, Stop, In_Valid;
   logic signed [15:0] Result0, Result1, Result2, Result3;
   logic signed [19:0] Acc_Out;
   logic               Acc_Valid, Busy, Overflow;

   logic clk_en;
   int   n_cmp;
   int   n_err;
   int   av_cnt;

`ifdef ACC_SAT_EN
   localparam logic signed [19:0] EXP_T4 = 20'sd524287;
`else
   localparam logic signed [19:0] EXP_T4 = 20'sd0;
`endif

   mult_result_accum dut (
      .Clock_20M (Clock_20M),
      .Ex_Rst_n  (Ex_Rst_n),
      .Start     (Start),
      .Stop      (Stop),
      .In_Valid  (In_Valid),
      .Result0   (Result0),
      .Result1   (Result1),
      .Result2   (Result2),
      .Result3   (Result3),
      .Acc_Out   (Acc_Out),
      .Acc_Valid (Acc_Valid),
      .Busy      (Busy),
      .Overflow  (Overflow)
   );

   // Gated clock so reset can be checked with no edges running
   initial begin
      Clock_20M = 1'b0;
      forever begin
         #25;
         if (clk_en) Clock_20M = ~Clock_20M;
      end
   end

   always @(negedge Clock_20M) if (Acc_Valid === 1'b1) av_cnt <= av_cnt + 1;

   task automatic cyc(input int n);
      repeat (n) @(negedge Clock_20M);
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      cyc(1);
      Start = 1'b0;
   endtask

   task automatic send_frames(input int n, input logic signed [15:0] a, input logic signed [15:0] b,
                              input logic signed [15:0] c, input logic signed [15:0] d, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) cyc(int'($urandom_range(0, 3)));
         In_Valid = 1'b1;
         Result0 = a; Result1 = b; Result2 = c; Result3 = d;
         cyc(1);
         In_Valid = 1'b0;
         Result0 = '0; Result1 = '0; Result2 = '0; Result3 = '0;
      end
   endtask

   // Observes Acc_Valid on the 1st..4th cycle after the last frame's edge
   task automatic watch_dump(output logic early, output logic hit, output logic late,
                             output logic signed [19:0] val);
      early = 1'b0;
      cyc(1); early = early | Acc_Valid;
      cyc(1); early = early | Acc_Valid;
      cyc(1); hit = Acc_Valid; val = Acc_Out;
      cyc(1); late = Acc_Valid;
   endtask

   task automatic test_reset();
      int av0;
      Ex_Rst_n = 1'b1;
      #5 Ex_Rst_n = 1'b0;
      #5;
      n_cmp++; if (Acc_Out !== 20'sd0) begin n_err++; $display("FAIL reset_acc_out got=%0d want=0", Acc_Out); end
      n_cmp++; if (Acc_Valid !== 1'b0) begin n_err++; $display("FAIL reset_acc_valid got=%b want=0", Acc_Valid); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", Busy); end
      n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b want=0", Overflow); end
      clk_en = 1'b1;
      cyc(2);
      Ex_Rst_n = 1'b1;
      cyc(1);
      av0 = av_cnt;
      send_frames(20, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      cyc(5);
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", Busy); end
      n_cmp++; if (av_cnt - av0 !== 0) begin n_err++; $display("FAIL idle_no_dump got=%0d want=0", av_cnt - av0); end
   endtask

   task automatic test_basic();
      logic early, hit, late;
      logic signed [19:0] val;
      pulse_start();
      n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL start_busy got=%b want=1", Busy); end
      send_frames(16, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      watch_dump(early, hit, late, val);
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL pos_early got=%b want=0", early); end
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL pos_valid got=%b want=1", hit); end
      n_cmp++; if (val !== 20'sd160) begin n_err++; $display("FAIL pos_sum got=%0d want=160", val); end
      n_cmp++; if (late !== 1'b0) begin n_err++; $display("FAIL pos_pulse_width got=%b want=0", late); end
      send_frames(16, -16'sd1, -16'sd2, -16'sd3, -16'sd4, 1'b0);
      watch_dump(early, hit, late, val);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL neg_valid got=%b want=1", hit); end
      n_cmp++; if (val !== -20'sd160) begin n_err++; $display("FAIL neg_sum got=%0d want=-160", val); end
      n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL neg_overflow got=%b want=0", Overflow); end
   endtask

   task automatic test_gaps();
      logic early, hit, late;
      logic signed [19:0] val;
      int av0;
      av0 = av_cnt;
      send_frames(16, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b1);
      watch_dump(early, hit, late, val);
      cyc(2);
      n_cmp++; if (val !== 20'sd160) begin n_err++; $display("FAIL gap_sum got=%0d want=160", val); end
      n_cmp++; if (av_cnt - av0 !== 1) begin n_err++; $display("FAIL gap_pulses got=%0d want=1", av_cnt - av0); end
   endtask

   task automatic test_overflow();
      logic early, hit, late;
      logic signed [19:0] val;
      pulse_start();
      send_frames(16, 16'sd16384, 16'sd16384, 16'sd16384, 16'sd16384, 1'b0);
      watch_dump(early, hit, late, val);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL ovf_valid got=%b want=1", hit); end
      n_cmp++; if (val !== EXP_T4) begin n_err++; $display("FAIL ovf_sum got=%0d want=%0d", val, EXP_T4); end
      n_cmp++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", Overflow); end
      pulse_start();
      n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b want=0", Overflow); end
   endtask

   task automatic test_stop();
      logic early, hit, late;
      logic signed [19:0] val;
      int av0;
      av0 = av_cnt;
      send_frames(5, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      Stop = 1'b1;
      cyc(1);
      Stop = 1'b0;
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got=%b want=0", Busy); end
      cyc(6);
      n_cmp++; if (av_cnt - av0 !== 0) begin n_err++; $display("FAIL stop_no_dump got=%0d want=0", av_cnt - av0); end
      n_cmp++; if (Acc_Out !== EXP_T4) begin n_err++; $display("FAIL stop_hold got=%0d want=%0d", Acc_Out, EXP_T4); end
      pulse_start();
      send_frames(16, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      watch_dump(early, hit, late, val);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL restart_valid got=%b want=1", hit); end
      n_cmp++; if (val !== 20'sd160) begin n_err++; $display("FAIL restart_sum got=%0d want=160", val); end
   endtask

   task automatic test_boundary();
      logic early, hit, late;
      logic signed [19:0] val;
      int av0;
      Start = 1'b1; Stop = 1'b1;
      cyc(1);
      Start = 1'b0; Stop = 1'b0;
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL start_stop_busy got=%b want=0", Busy); end
      pulse_start();
      send_frames(7, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      #10 Ex_Rst_n = 1'b0;
      #5;
      n_cmp++; if (Acc_Out !== 20'sd0) begin n_err++; $display("FAIL midrst_acc_out got=%0d want=0", Acc_Out); end
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", Busy); end
      cyc(1);
      Ex_Rst_n = 1'b1;
      cyc(1);
      pulse_start();
      send_frames(10, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      pulse_start();
      av0 = av_cnt;
      send_frames(16, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0);
      watch_dump(early, hit, late, val);
      cyc(2);
      n_cmp++; if (val !== 20'sd160) begin n_err++; $display("FAIL rewindow_sum got=%0d want=160", val); end
      n_cmp++; if (av_cnt - av0 !== 1) begin n_err++; $display("FAIL rewindow_pulses got=%0d want=1", av_cnt - av0); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; av_cnt = 0;
      clk_en = 1'b0;
      Ex_Rst_n = 1'b1;
      Start = 1'b0; Stop = 1'b0; In_Valid = 1'b0;
      Result0 = '0; Result1 = '0; Result2 = '0; Result3 = '0;
      test_reset();
      test_basic();
      test_gaps();
      test_overflow();
      test_stop();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
